thermal_plant: RTL
==================

Name: thermal_plant

Overview:
- Behavioural-synthesisable room thermal model; drives the 5-bit temperature input of the air-conditioning controller and consumes its heating/cooling outputs, closing the loop.
- Temperature steps up under heating, down under cooling, and drifts toward ambient otherwise.
- Flags contradictory commands and saturation.
- Used in closed-loop benches and on-board demos.

Parameters:
- TEMP_INIT, 20, temperature loaded at reset (0..31).
- AMBIENT, 18, drift target (0..31).
- STEP_CYCLES, 3, clock cycles per thermal tick (>=1).
- DRIFT_DIV, 4, thermal ticks per one-degree drift step (>=1).
- TEMP_MIN, 0, lower saturation bound.
- TEMP_MAX, 31, upper saturation bound.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  model enable; 0 freezes temp and counters.
- heating  in  1  heater command from the controller.
- cooling  in  1  cooler command from the controller.
- load  in  1  synchronous load of load_temp.
- load_temp  in  5  value for load, clamped to [TEMP_MIN, TEMP_MAX].
- temp  out  5  current room temperature.
- temp_upd  out  1  one-cycle pulse, coincident with any change of temp.
- mode  out  3  encoded FSM state.
- fault  out  1  heating and cooling both asserted.
- sat  out  1  temp == TEMP_MIN or temp == TEMP_MAX.

Behaviour:
- Reset (async assert, sync release):
  - temp = TEMP_INIT; prescaler = 0; drift counter = 0.
  - mode = IDLE; temp_upd = 0; fault = 0; sat derived combinationally from temp.
- Prescaler:
  - Counts 0..STEP_CYCLES-1 while en=1 and mode != FAULT.
  - tick is internal, high on the cycle the count equals STEP_CYCLES-1; the count then wraps to 0.
  - Counter holds when en=0.
- FSM (registered, evaluated every edge):
  - IDLE: en=0.
  - HEAT: en and heating and !cooling.
  - COOL: en and cooling and !heating.
  - DRIFT: en and neither command.
  - FAULT: en and heating and cooling.
  - Transitions take effect on the next edge. Mode encoding is IDLE=0, HEAT=1, COOL=2, DRIFT=3, FAULT=4.
- FAULT:
  - fault=1; temp frozen; prescaler and drift counter cleared.
  - Exit only after both commands are low on one edge, going to DRIFT. Exit to IDLE if en=0.
- Temperature update, on tick, according to the current registered mode:
  - HEAT: temp+1, saturating at TEMP_MAX.
  - COOL: temp-1, saturating at TEMP_MIN.
  - DRIFT: drift counter increments. On reaching DRIFT_DIV-1 it wraps to 0 and temp moves 1 toward AMBIENT; no change if temp == AMBIENT.
  - The drift counter clears on any entry to HEAT or COOL.
- Arithmetic:
  - Internal 6-bit compare; no 5-bit wrap-around is permitted.
  - Saturated steps do not pulse temp_upd.
- Load:
  - Has priority over tick. temp = clamp(load_temp); prescaler and drift counter reset to 0.
  - temp_upd pulses only if the value changed.
- Latency:
  - temp changes on the edge after tick.
  - A command change reaches temp after at most 1 + STEP_CYCLES cycles.
- Reset mid-operation: immediate return to reset values, regardless of mode.

Optional Feature:
- Macro: THERMAL_NOISE_EN.
- Defined:
  - Adds an 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5 at reset), advanced on every tick.
  - In DRIFT, a drift step is skipped when lfsr[0]=1.
  - In HEAT/COOL, a step is doubled (±2, still saturating) when lfsr[7:6]==2'b11.
- Undefined: no LFSR; behaviour is exactly deterministic as above.

Decomposition:
- Package thermal_pkg: TEMP_W=5, mode encoding constants (IDLE..FAULT), LFSR seed and taps.
- Sub-module thermal_tick: parameterised prescaler with en/clear inputs and a tick output.
- FSM, temperature datapath and drift counter live in thermal_plant.

Test Plan:
- Reset check: rst_n low mid-run with temp=25 -> temp=20, mode=0, fault=0, temp_upd=0 immediately, without a clock edge.
- Heat ramp: en=1, heating=1 for 40 cycles -> temp 20,21,22... one step per 3 cycles; saturates at 31 with sat=1 and no further temp_upd.
- Cool from load: load_temp=2 with load, then cooling=1 -> 1, then 0, then holds at 0 with sat=1.
- Drift: temp=22, no commands -> decrements once per 12 cycles to 18, then stable.
- Fault: heating=cooling=1 at temp=20 for 10 cycles -> fault=1, mode=4, temp stays 20. Drop both -> mode=3 on the next edge, fault=0.
- Enable freeze: en=0 mid-HEAT for 9 cycles -> temp and prescaler hold, mode=0. Re-enable -> stepping resumes from the held prescaler count.

Source files
------------

// File: rtl/thermal_pkg.sv
// Purpose: shared constants for the room thermal model (width, mode encoding, noise LFSR).
// Latency: n/a (declarations only).
// Backpressure: n/a. Optional noise LFSR constants are used only when THERMAL_NOISE_EN is defined.
package thermal_pkg;

  localparam int TEMP_W = 5;

  typedef enum logic [2:0] {
    MODE_IDLE  = 3'd0,
    MODE_HEAT  = 3'd1,
    MODE_COOL  = 3'd2,
    MODE_DRIFT = 3'd3,
    MODE_FAULT = 3'd4
  } mode_e;

  // Fibonacci LFSR, taps at stages 8,6,5,4 (bit indices 7,5,4,3).
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/thermal_tick.sv
// Purpose: thermal prescaler; emits one tick every STEP_CYCLES enabled cycles.
// Latency: tick is combinational on the cycle the count is at STEP_CYCLES-1.
// Backpressure: none; i_en=0 holds the count, i_clr forces it to 0 and masks the tick.
module thermal_tick #(
  parameter int STEP_CYCLES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);
  assign o_tick = i_en && !i_clr && w_last;

  // Free-running modulo counter, frozen when disabled, cleared on request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/thermal_plant.sv
// Purpose: closed-loop room temperature model driven by heat/cool commands; THERMAL_NOISE_EN adds LFSR noise.
// Latency: temp moves on the edge after a prescaler tick; a command change reaches temp within 1+STEP_CYCLES cycles.
// Backpressure: none; en=0 freezes temp and counters, load overrides any tick.
module thermal_plant
  import thermal_pkg::*;
#(
  parameter int TEMP_INIT   = 20,
  parameter int AMBIENT     = 18,
  parameter int STEP_CYCLES = 3,
  parameter int DRIFT_DIV   = 4,
  parameter int TEMP_MIN    = 0,
  parameter int TEMP_MAX    = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              heating,
  input  logic              cooling,
  input  logic              load,
  input  logic [TEMP_W-1:0] load_temp,
  output logic [TEMP_W-1:0] temp,
  output logic              temp_upd,
  output logic [2:0]        mode,
  output logic              fault,
  output logic              sat
);

  localparam int DW = (DRIFT_DIV > 1) ? $clog2(DRIFT_DIV) : 1;
  localparam logic [DW-1:0] DRIFT_LAST = DW'(DRIFT_DIV - 1);
  // One extra bit so saturation compares never wrap.
  localparam logic [TEMP_W:0] MIN6 = (TEMP_W+1)'(TEMP_MIN);
  localparam logic [TEMP_W:0] MAX6 = (TEMP_W+1)'(TEMP_MAX);
  localparam logic [TEMP_W:0] AMB6 = (TEMP_W+1)'(AMBIENT);

  mode_e             r_mode, w_mode_nxt;
  logic [TEMP_W-1:0] r_temp, w_temp_nxt;
  logic [DW-1:0]     r_drift, w_drift_nxt;
  logic              r_temp_upd;
  logic              w_tick, w_pre_en, w_pre_clr;
  logic [TEMP_W:0]   w_temp6, w_load6, w_step, w_up, w_dn;
  logic              w_skip;

  assign w_pre_en  = en && (r_mode != MODE_FAULT);
  assign w_pre_clr = load || (r_mode == MODE_FAULT);

  thermal_tick #(.STEP_CYCLES(STEP_CYCLES)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_pre_en),
    .i_clr  (w_pre_clr),
    .o_tick (w_tick)
  );

`ifdef THERMAL_NOISE_EN
  logic [7:0] r_lfsr;

  // Noise source advances once per thermal tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= LFSR_SEED;
    end else if (w_tick) begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign w_step = (r_lfsr[7:6] == 2'b11) ? (TEMP_W+1)'(2) : (TEMP_W+1)'(1);
  assign w_skip = r_lfsr[0];
`else
  assign w_step = (TEMP_W+1)'(1);
  assign w_skip = 1'b0;
`endif

  assign w_temp6 = {1'b0, r_temp};
  assign w_load6 = {1'b0, load_temp};
  assign w_up    = w_temp6 + w_step;
  assign w_dn    = w_temp6 - w_step;

  // Mode selection; FAULT is sticky until both commands drop together.
  always_comb begin
    w_mode_nxt = r_mode;
    if (!en) begin
      w_mode_nxt = MODE_IDLE;
    end else if (r_mode == MODE_FAULT) begin
      if (!heating && !cooling) w_mode_nxt = MODE_DRIFT;
    end else if (heating && cooling) begin
      w_mode_nxt = MODE_FAULT;
    end else if (heating) begin
      w_mode_nxt = MODE_HEAT;
    end else if (cooling) begin
      w_mode_nxt = MODE_COOL;
    end else begin
      w_mode_nxt = MODE_DRIFT;
    end
  end

  // Temperature and drift-counter datapath; load wins over any tick.
  always_comb begin
    w_temp_nxt  = r_temp;
    w_drift_nxt = r_drift;
    if (load) begin
      if (w_load6 < MIN6)      w_temp_nxt = MIN6[TEMP_W-1:0];
      else if (w_load6 > MAX6) w_temp_nxt = MAX6[TEMP_W-1:0];
      else                     w_temp_nxt = load_temp;
      w_drift_nxt = '0;
    end else if (r_mode == MODE_FAULT) begin
      w_drift_nxt = '0;
    end else if (w_tick) begin
      unique case (r_mode)
        MODE_HEAT: w_temp_nxt = (w_up > MAX6) ? MAX6[TEMP_W-1:0] : w_up[TEMP_W-1:0];
        MODE_COOL: w_temp_nxt = (w_temp6 < MIN6 + w_step) ? MIN6[TEMP_W-1:0] : w_dn[TEMP_W-1:0];
        MODE_DRIFT: begin
          if (r_drift == DRIFT_LAST) begin
            w_drift_nxt = '0;
            if (!w_skip) begin
              if (w_temp6 > AMB6)      w_temp_nxt = r_temp - 1'b1;
              else if (w_temp6 < AMB6) w_temp_nxt = r_temp + 1'b1;
            end
          end else begin
            w_drift_nxt = r_drift + 1'b1;
          end
        end
        default: ;
      endcase
    end
    // Entering an active heat/cool phase restarts the drift accumulation.
    if ((w_mode_nxt == MODE_HEAT && r_mode != MODE_HEAT) ||
        (w_mode_nxt == MODE_COOL && r_mode != MODE_COOL)) begin
      w_drift_nxt = '0;
    end
  end

  // State registers; temp_upd flags exactly the edges where temp changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode     <= MODE_IDLE;
      r_temp     <= TEMP_W'(TEMP_INIT);
      r_drift    <= '0;
      r_temp_upd <= 1'b0;
    end else begin
      r_mode     <= w_mode_nxt;
      r_temp     <= w_temp_nxt;
      r_drift    <= w_drift_nxt;
      r_temp_upd <= (w_temp_nxt != r_temp);
    end
  end

  assign temp     = r_temp;
  assign temp_upd = r_temp_upd;
  assign mode     = r_mode;
  assign fault    = (r_mode == MODE_FAULT);
  assign sat      = (w_temp6 == MIN6) || (w_temp6 == MAX6);

endmodule
